alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one instance of the team's 32-bit `alu` combinational unit between NREQ independent requesters, e.g. the integer pipe, the branch comparator and the address generator.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time; operands and result registered.
- Sits between the requesters and the ALU, so the ALU stays purely combinational.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width (fixed to 32 by the alu; present for clarity).
- IDW, 3, width of grant index (clog2(NREQ), minimum 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_ctl  in  4*NREQ  packed ALU control codes, requester i at [4i+3:4i].
- req_a  in  W*NREQ  packed operand A.
- req_b  in  W*NREQ  packed operand B.
- rsp_valid  out  NREQ  one-hot response valid to the owning requester.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_out  out  W  result (shared bus, qualified by rsp_valid).
- rsp_zero  out  1  result == 0.
- rsp_err  out  1  ctl was not a legal code.
- busy  out  1  state != IDLE.
- grant_id  out  IDW  index of current owner (valid when busy).

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; rr pointer=0; req_ready=0; rsp_valid=0; rsp_out=0; rsp_zero=0; rsp_err=0; grant_id=0; busy=0. Reset mid-operation discards the operation with no response.
- Legal ctl codes: 0 and, 1 or, 2 add, 6 sub, 7 slt, 12 nor, 13 xor.
- Any other ctl: result 0, rsp_zero=1, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: exactly one bit is high, for the round-robin winner among asserted req_valid.
  - Search starts at pointer, increments mod NREQ.
  - Handshake (valid & ready) in cycle T: latch ctl/a/b and grant_id; pointer <= winner+1 mod NREQ; go to EXEC.
- EXEC (T+1):
  - Latched operands drive the alu.
  - Register out, zero and err into rsp_*; go to RESP.
  - req_ready=0.
- RESP (T+2 onward):
  - rsp_valid[grant_id]=1, with rsp_out/zero/err held stable until rsp_ready[grant_id] is high.
  - On that handshake go to IDLE.
  - rsp_valid deasserts the following cycle.
  - rsp_ready of non-owners is ignored.
- Minimum latency request→response: 2 cycles. Peak throughput: one op per 3 cycles.
- No request is accepted while busy; requesters must hold req_valid and payload stable until accepted.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Simultaneous requests: the winner is the first asserted index at or after pointer.
- Response-channel behaviour:
  - Back-to-back: a response handshake in RESP and a new req_valid in the same cycle does not overlap. The new request is granted in the following IDLE cycle.
  - rsp_ready held high permanently: RESP lasts exactly 1 cycle.
  - Withdrawal of req_valid before grant is legal; there is no response.
- Arithmetic is inherited from the alu: wraparound add/sub, no overflow flag exported; slt is signed two's complement.

Decomposition:
- Package alu_pkg holds:
  - localparams for the ALU ctl codes (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_XOR=13);
  - the FSM state encoding;
  - a function is_legal_ctl.
- Sub-module rr_arbiter (NREQ):
  - inputs: req vector, pointer;
  - outputs: one-hot grant, binary index.
  - Purely combinational, unit-testable alone.
- The existing alu is instantiated once inside this block.

Test Plan:
- Single op: requester 0 sends ctl=2, a=7, b=5 → req_ready[0] same cycle; rsp_valid=01 two cycles later; rsp_out=12, zero=0, err=0.
- Contention: both requesters valid from cycle 0, pointer=0 → order of grants is 0, 1, 0, 1. Requester 0 sends sub 3-3 and gets rsp_out=0, rsp_zero=1. Requester 1 sends slt a=0xFFFFFFFF, b=1 and gets rsp_out=1.
- Response backpressure: rsp_ready[1] low 4 cycles → rsp_valid[1] and rsp_out stay stable; no new grant to requester 0 until the handshake; then requester 0 is granted in the next cycle.
- Illegal ctl=4, a=0xDEAD, b=1 → rsp_out=0, rsp_zero=1, rsp_err=1; the next legal op clears err.
- Reset mid-EXEC: rst_n low for 1 cycle → all outputs 0 immediately; no rsp_valid afterwards; pointer=0 on the next grant.
- Coverage sweep: nor 0,0 → 0xFFFFFFFF; xor 0xF0F0, 0xFFFF → 0x0F0F; add 0x7FFFFFFF+1 → 0x80000000, err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: ALU control codes, the
// arbiter FSM state encoding and a legality check for control codes.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_legal_ctl(input logic [3:0] ctl);
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_XOR: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU.
// Ports: ctl_i (operation code), a_i/b_i (operands),
//        y_o (result), zero_o (y_o == 0), err_o (ctl_i not a legal code).
// Unknown codes yield a zero result with err_o set.
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   ctl_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         zero_o,
  output logic         err_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned (which would infer a latch).
    y_o   = '0;
    err_o = !is_legal_ctl(ctl_i);
    case (ctl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_NOR: y_o = ~(a_i | b_i);
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req_i (request vector), ptr_i (highest-priority index),
//        grant_o (one-hot winner, all zero if no request),
//        idx_o (binary index of the winner, 0 if no request).
// The winner is the first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters.
// Ports: clk/rst_n; req_valid/req_ready/req_ctl/req_a/req_b form the packed
//        per-requester request channels; rsp_valid/rsp_ready the per-requester
//        response handshake; rsp_out/rsp_zero/rsp_err the shared response
//        payload; busy (not idle) and grant_id (current owner).
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates registered
// operands) -> RESP (hold result until the owner accepts it).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_ctl,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_out,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [3:0]     ctl_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   rsp_out_q;
  logic           rsp_zero_q, rsp_err_q;
  logic           load_op, load_rsp;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx, next_ptr;
  logic [3:0]      sel_ctl;
  logic [W-1:0]    sel_a, sel_b, alu_y;
  logic            alu_zero, alu_err;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  alu #(.W(W)) u_alu (
    .ctl_i  (ctl_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .y_o    (alu_y),
    .zero_o (alu_zero),
    .err_o  (alu_err)
  );

  assign sel_ctl  = req_ctl[4*int'(arb_idx) +: 4];
  assign sel_a    = req_a[W*int'(arb_idx) +: W];
  assign sel_b    = req_b[W*int'(arb_idx) +: W];
  assign next_ptr = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    load_op   = 1'b0;
    load_rsp  = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      ST_IDLE: begin
        // Ready is also masked by rst_n so nothing is offered while reset
        // is held, even though the state register already reads IDLE.
        req_ready = rst_n ? arb_grant : '0;
        if (|req_valid) begin
          load_op = 1'b1;
          gid_d   = arb_idx;
          ptr_d   = next_ptr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        load_rsp = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[int'(gid_q)] = 1'b1;
        if (rsp_ready[int'(gid_q)]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gid_q      <= '0;
      // NOTE: the operand registers are reset too; they are few and keeping
      // them defined avoids X on the ALU inputs before the first grant.
      ctl_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_out_q  <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      if (load_op) begin
        ctl_q <= sel_ctl;
        a_q   <= sel_a;
        b_q   <= sel_b;
      end
      if (load_rsp) begin
        rsp_out_q  <= alu_y;
        rsp_zero_q <= alu_zero;
        rsp_err_q  <= alu_err;
      end
    end
  end

  assign rsp_out  = rsp_out_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = gid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_ctl;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_out;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  alu_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctl   (req_ctl),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference ALU straight from the operation table: {err, zero, result}.
  function automatic logic [33:0] golden(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    logic        e;
    e = 1'b0;
    case (c)
      4'd0:    y = a & b;
      4'd1:    y = a | b;
      4'd2:    y = a + b;
      4'd6:    y = a - b;
      4'd7:    y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   y = ~(a | b);
      4'd13:   y = a ^ b;
      default: begin y = 32'd0; e = 1'b1; end
    endcase
    return {e, (y == 32'd0), y};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_phase: 0 = nothing in flight, 1 = op accepted last edge, 2 = result offered.
  int              m_phase = 0;
  int              m_ptr   = 0;
  int              m_owner = 0;
  logic [3:0]      m_ctl;
  logic [31:0]     m_a, m_b;
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] exp_ready, exp_valid;
  logic [33:0]     g;
  int              win;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_grant_id", grant_id, '0);
      check("rst_rsp_out", rsp_out, '0);
      check("rst_flags", {rsp_zero, rsp_err}, 2'b00);
      m_phase = 0;
      m_ptr   = 0;
      acc     = '0;
    end else begin
      exp_ready = '0;
      exp_valid = '0;
      win       = -1;
      if (m_phase == 0)
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      if (win >= 0) exp_ready[win] = 1'b1;
      if (m_phase == 2) exp_valid[m_owner] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("busy", busy, m_phase != 0);
      if (m_phase != 0) check("grant_id", grant_id, m_owner);
      if (m_phase == 2) begin
        g = golden(m_ctl, m_a, m_b);
        check("rsp_out", rsp_out, g[31:0]);
        check("rsp_zero", rsp_zero, g[32]);
        check("rsp_err", rsp_err, g[33]);
      end
      acc = exp_ready & req_valid;
      case (m_phase)
        0: if (win >= 0) begin
             m_owner = win;
             m_ctl   = req_ctl[4*win +: 4];
             m_a     = req_a[W*win +: W];
             m_b     = req_b[W*win +: W];
             m_ptr   = (win + 1) % NREQ;
             m_phase = 1;
           end
        1: m_phase = 2;
        default: if (rsp_ready[m_owner]) m_phase = 0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_ctl[4*i +: 4]  = c;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (rsp_valid == '0 && lat < 30) begin
      tick();
      lat++;
    end
    if (lat >= 30) fail_now(name);
  endtask

  // One operation from requester i with rsp_ready high; literal expectations.
  task automatic single_op(input string name, input int i, input logic [3:0] c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_out, input logic e_zero, input logic e_err);
    logic [NREQ-1:0] oh;
    int              lat;
    oh    = '0;
    oh[i] = 1'b1;
    drive(i, 1'b1, c, a, b);
    #1;
    check({name, "_ready"}, req_ready, oh);
    tick();
    req_valid[i] = 1'b0;
    wait_rsp({name, "_wait"}, lat);
    check({name, "_latency"}, lat + 1, 2);
    check({name, "_valid"}, rsp_valid, oh);
    check({name, "_out"}, rsp_out, e_out);
    check({name, "_zero"}, rsp_zero, e_zero);
    check({name, "_err"}, rsp_err, e_err);
    tick();
  endtask

  // ---------------- main sequence ----------------
  logic [NREQ-1:0] pending;
  int              grants, got, lat;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_ctl   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    tick();
    tick();
    rst_n = 1'b1;

    // Single op: 7 + 5.
    single_op("t1_add", 0, 4'd2, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0);

    // Contention from a fresh pointer: grants alternate 0,1,0,1.
    do_reset();
    drive(0, 1'b1, 4'd6, 32'd3, 32'd3);
    drive(1, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1);
    rsp_ready = '1;
    #1;
    grants = 0;
    for (int cyc = 0; cyc < 60 && grants < 4; cyc++) begin
      if (req_ready != '0) begin
        got = req_ready[1] ? 1 : 0;
        check($sformatf("t2_grant%0d", grants), got, grants % 2);
        grants++;
      end
      if (rsp_valid[0]) check("t2_r0_out_zero", {rsp_zero, rsp_out}, {1'b1, 32'd0});
      if (rsp_valid[1]) check("t2_r1_out", {rsp_zero, rsp_out}, {1'b0, 32'd1});
      tick();
    end
    if (grants < 4) fail_now("t2_grants");
    req_valid = '0;
    for (int cyc = 0; cyc < 10 && busy; cyc++) tick();
    tick();

    // Response backpressure on requester 1; requester 0 waits meanwhile.
    do_reset();
    rsp_ready = 2'b00;
    drive(1, 1'b1, 4'd2, 32'd10, 32'd20);
    #1;
    tick();
    req_valid[1] = 1'b0;
    wait_rsp("t3_wait", lat);
    drive(0, 1'b1, 4'd4, 32'hDEAD, 32'd1);
    rsp_ready = 2'b01;  // non-owner ready must be ignored
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_hold_valid%0d", k), rsp_valid, 2'b10);
      check($sformatf("t3_hold_out%0d", k), rsp_out, 32'd30);
      check($sformatf("t3_no_grant%0d", k), req_ready, 2'b00);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    check("t3_next_grant", req_ready, 2'b01);
    check("t3_valid_drop", rsp_valid, 2'b00);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready    = '1;

    // Illegal ctl from requester 0, then a legal op clears err.
    wait_rsp("t4_wait", lat);
    check("t4_illegal", {rsp_err, rsp_zero, rsp_out}, {1'b1, 1'b1, 32'd0});
    tick();
    single_op("t4_xor", 0, 4'd13, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0, 1'b0);

    // Coverage sweep.
    single_op("t6_nor", 1, 4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    single_op("t6_add_wrap", 0, 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
    single_op("t6_slt_pos", 1, 4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);

    // Reset while in EXEC: outputs clear at once, no response, pointer back to 0.
    drive(0, 1'b1, 4'd2, 32'd1, 32'd2);
    #1;
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("t5_rst_now", {busy, rsp_valid, rsp_zero, rsp_err}, '0);
    check("t5_rst_out", rsp_out, 32'd0);
    check("t5_rst_gid", grant_id, '0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t5_no_rsp%0d", k), rsp_valid, 2'b00);
      tick();
    end
    drive(0, 1'b1, 4'd0, 32'hFF00, 32'h0FF0);
    drive(1, 1'b1, 4'd1, 32'h1, 32'h2);
    #1;
    check("t5_ptr_zero", req_ready, 2'b01);

    // Randomized traffic; the model process checks every cycle.
    pending = req_valid;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          pending[i]   = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (!pending[i] && $urandom_range(99) < 40) begin
          logic [3:0]  c;
          logic [31:0] a, b;
          case ($urandom_range(8))
            0: c = 4'd0;  1: c = 4'd1;  2: c = 4'd2;  3: c = 4'd6;
            4: c = 4'd7;  5: c = 4'd12; 6: c = 4'd13;
            default: c = 4'($urandom_range(15));
          endcase
          b = $urandom();
          a = ($urandom_range(3) == 0) ? b : $urandom();
          drive(i, 1'b1, c, a, b);
          pending[i] = 1'b1;
        end else if (pending[i] && $urandom_range(99) < 3) begin
          req_valid[i] = 1'b0;
          pending[i]   = 1'b0;
        end
        rsp_ready[i] = ($urandom_range(99) < 60);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
